// File: rtl/keypad_event.sv
// keypad_event: debounced key event generator for the 20-button calculator
// front end. Raw button levels are synchronised, priority-encoded to a 5-bit
// code and debounced. Each accepted press produces one single-cycle strobe,
// optionally followed by auto-repeat strobes while the key stays held.
//
// Parameters:
//   DEBOUNCE      - consecutive stable samples to accept a press/release (2..255)
//   REPEAT_DELAY  - cycles from the initial strobe to the first repeat (2..65535)
//   REPEAT_PERIOD - cycles between subsequent repeats (2..65535)
//   REPEAT_EN     - 1 enables auto-repeat, 0 disables it
//
// Ports:
//   clk    - system clock
//   reset  - asynchronous, active-high
//   inkeys - raw active-high button levels, asynchronous to clk
//   strobe - one-cycle pulse per accepted press or repeat
//   outkey - code (0..19) of the accepted key, held until the next strobe
//   held   - high while an accepted key is considered held
//   multi  - high when more than one synchronised key bit is set
module keypad_event #(
  parameter int unsigned DEBOUNCE      = 3,
  parameter int unsigned REPEAT_DELAY  = 50,
  parameter int unsigned REPEAT_PERIOD = 10,
  parameter int unsigned REPEAT_EN     = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] inkeys,
  output logic        strobe,
  output logic [4:0]  outkey,
  output logic        held,
  output logic        multi
);

  localparam logic [7:0]  DCNT_LAST   = 8'(DEBOUNCE - 1);
  localparam logic [15:0] DELAY_LAST  = 16'(REPEAT_DELAY - 1);
  localparam logic [15:0] PERIOD_LAST = 16'(REPEAT_PERIOD - 1);
  localparam logic        REP_ON      = (REPEAT_EN != 0);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_DB,
    HELD,
    REPEAT,
    REL_DB
  } state_t;

  state_t      state;
  logic [19:0] sync1;
  logic [19:0] s;
  logic [7:0]  dcnt;
  logic [15:0] rcnt;
  logic [4:0]  cand;

  logic        any;
  logic [4:0]  code;
  logic [4:0]  ones;
  logic        many;
  logic [15:0] rep_last;

  // Priority encoder (highest index wins) and population count.
  always_comb begin
    code = '0;
    ones = '0;
    for (int unsigned i = 0; i < 20; i++) begin
      if (s[i]) begin
        code = 5'(i);
        ones = ones + 5'd1;
      end
    end
    any  = |s;
    many = (ones > 5'd1);
  end

  // The first repeat waits REPEAT_DELAY; once in REPEAT, REPEAT_PERIOD applies.
  always_comb begin
    rep_last = DELAY_LAST;
    if (state == REPEAT) rep_last = PERIOD_LAST;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      sync1  <= '0;
      s      <= '0;
      dcnt   <= '0;
      rcnt   <= '0;
      cand   <= '0;
      strobe <= 1'b0;
      outkey <= '0;
      held   <= 1'b0;
      multi  <= 1'b0;
    end else begin
      sync1  <= inkeys;
      s      <= sync1;
      multi  <= many;
      strobe <= 1'b0;
      case (state)
        IDLE: begin
          if (any) begin
            dcnt  <= 8'd1;
            cand  <= code;
            state <= PRESS_DB;
          end
        end
        PRESS_DB: begin
          if (!any) begin
            state <= IDLE;
          end else if (code != cand) begin
            // A different key restarts the count with the new candidate.
            cand <= code;
            dcnt <= 8'd1;
          end else if (dcnt == DCNT_LAST) begin
            strobe <= 1'b1;
            outkey <= cand;
            held   <= 1'b1;
            rcnt   <= '0;
            state  <= HELD;
          end else begin
            dcnt <= dcnt + 8'd1;
          end
        end
        HELD, REPEAT: begin
          // Key-code changes while held are deliberately ignored.
          if (!any) begin
            dcnt  <= 8'd1;
            state <= REL_DB;
          end else if (REP_ON && rcnt == rep_last) begin
            strobe <= 1'b1;
            rcnt   <= '0;
            state  <= REPEAT;
          end else if (rcnt != '1) begin
            rcnt <= rcnt + 16'd1;
          end
        end
        REL_DB: begin
          // A returning key re-arms the initial repeat delay without a strobe.
          if (any) begin
            rcnt  <= '0;
            state <= HELD;
          end else if (dcnt == DCNT_LAST) begin
            held  <= 1'b0;
            state <= IDLE;
          end else begin
            dcnt <= dcnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_event.sv
// Testbench for keypad_event: two instances (repeat disabled / repeat with
// delay 5, period 2) share one stimulus. A run-length based reference model
// predicts every output each cycle; a vector table and hand-written
// sequences add targeted checks.
module tb_keypad_event;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] inkeys;
  logic        sa, ha, ma, sb, hb, mb;
  logic [4:0]  ka, kb;

  always #5 clk = ~clk;

  keypad_event #(.DEBOUNCE(3), .REPEAT_DELAY(5), .REPEAT_PERIOD(2), .REPEAT_EN(0)) dut_a (
    .clk(clk), .reset(reset), .inkeys(inkeys),
    .strobe(sa), .outkey(ka), .held(ha), .multi(ma)
  );

  keypad_event #(.DEBOUNCE(3), .REPEAT_DELAY(5), .REPEAT_PERIOD(2), .REPEAT_EN(1)) dut_b (
    .clk(clk), .reset(reset), .inkeys(inkeys),
    .strobe(sb), .outkey(kb), .held(hb), .multi(mb)
  );

  localparam int DB = 3;

  // Reference model: press accepted after DB consecutive samples of the same
  // non-zero code; release after DB consecutive all-zero samples; repeats
  // timed by cycles since the last strobe or re-grab.
  typedef struct {
    logic [19:0] p1, p2;
    bit          pressed;
    int          run, zrun, since, reps;
    logic [4:0]  cand, key;
    bit          strobe, held, multi;
  } mstate_t;

  function automatic mstate_t mstep(input mstate_t st, input logic [19:0] k,
                                    input int rep_en, input int rd, input int rp);
    mstate_t     n;
    logic [19:0] sv;
    int          pc;
    int          hi;
    n  = st;
    sv = st.p2;
    pc = 0;
    hi = -1;
    for (int i = 0; i < 20; i++) if (sv[i]) begin pc++; hi = i; end
    n.p2 = st.p1;
    n.p1 = k;
    n.multi = (pc > 1);
    n.strobe = 0;
    if (!n.pressed) begin
      if (hi < 0) n.run = 0;
      else if (n.run > 0 && 5'(hi) == n.cand) n.run++;
      else begin n.cand = 5'(hi); n.run = 1; end
      if (n.run == DB) begin
        n.strobe = 1; n.key = n.cand; n.pressed = 1; n.held = 1;
        n.since = 0; n.reps = 0; n.zrun = 0; n.run = 0;
      end
    end else if (hi < 0) begin
      n.zrun++;
      if (n.zrun == DB) begin n.pressed = 0; n.held = 0; n.zrun = 0; end
    end else if (n.zrun > 0) begin
      n.zrun = 0; n.since = 0; n.reps = 0;
    end else begin
      n.since++;
      if (rep_en != 0 && n.since == ((n.reps == 0) ? rd : rp)) begin
        n.strobe = 1; n.since = 0; n.reps++;
      end
    end
    return n;
  endfunction

  mstate_t mst_a, mst_b, mzero;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  int str_a = 0, str_b = 0, last_a = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick;
    logic [19:0] k;
    k = inkeys;
    @(posedge clk);
    #1;
    cyc++;
    if (reset) begin
      mst_a = mzero;
      mst_b = mzero;
    end else begin
      mst_a = mstep(mst_a, k, 0, 5, 2);
      mst_b = mstep(mst_b, k, 1, 5, 2);
    end
    check("model_a", {sa, ka, ha, ma}, {mst_a.strobe, mst_a.key, mst_a.held, mst_a.multi});
    check("model_b", {sb, kb, hb, mb}, {mst_b.strobe, mst_b.key, mst_b.held, mst_b.multi});
    if (sa) begin str_a++; last_a = cyc; end
    if (sb) str_b++;
  endtask

  typedef struct {
    logic [19:0] keys;
    int          hold;
    int          exp_a;
    int          exp_b;
    logic [4:0]  key;
  } vec_t;

  vec_t tbl[7];
  int   c0;
  int   w;
  logic [19:0] rk;

  initial begin
    mzero = '{default: '0};
    mst_a = mzero;
    mst_b = mzero;
    tbl[0] = '{20'h00020, 20, 1, 8, 5'd5};
    tbl[1] = '{20'h20000, 20, 1, 8, 5'd17};
    tbl[2] = '{20'h80010, 12, 1, 4, 5'd19};
    tbl[3] = '{20'h00200,  2, 0, 0, 5'd19};
    tbl[4] = '{20'h00001,  3, 1, 1, 5'd0};
    tbl[5] = '{20'h00800,  9, 1, 2, 5'd11};
    tbl[6] = '{20'h00800, 10, 1, 3, 5'd11};

    reset  = 1'b1;
    inkeys = '0;
    #1;
    check("reset_state", {sa, ka, ha, ma, sb, kb, hb, mb}, 32'h0);
    repeat (3) tick;
    reset = 1'b0;
    repeat (2) tick;

    // Vector table
    for (int i = 0; i < 7; i++) begin
      str_a = 0; str_b = 0;
      inkeys = tbl[i].keys;
      repeat (tbl[i].hold) tick;
      inkeys = '0;
      repeat (8) tick;
      check("tbl_strobes_a", str_a, tbl[i].exp_a);
      check("tbl_strobes_b", str_b, tbl[i].exp_b);
      check("tbl_outkey", ka, tbl[i].key);
      check("tbl_held_low", ha, 0);
    end

    // Press bounce: 1,0,1,0 then stable
    str_a = 0;
    inkeys = 20'h00080; tick;
    inkeys = '0;        tick;
    inkeys = 20'h00080; tick;
    inkeys = '0;        tick;
    inkeys = 20'h00080; c0 = cyc;
    repeat (8) tick;
    check("bounce_count", str_a, 1);
    check("bounce_latency", last_a - c0, 5);
    check("bounce_key", ka, 7);
    inkeys = '0; repeat (8) tick;

    // Key change during debounce
    str_a = 0;
    inkeys = 20'h00008; repeat (2) tick;
    inkeys = 20'h01000; c0 = cyc;
    repeat (8) tick;
    check("change_count", str_a, 1);
    check("change_latency", last_a - c0, 5);
    check("change_key", ka, 12);
    inkeys = '0; repeat (8) tick;

    // Simultaneous keys and a key added while held
    str_a = 0;
    inkeys = 20'h80010;
    repeat (2) tick;
    check("multi_lag2", ma, 0);
    tick;
    check("multi_lag3", ma, 1);
    repeat (4) tick;
    inkeys = 20'h80011;
    repeat (10) tick;
    check("multi_count", str_a, 1);
    check("multi_key", ka, 19);
    inkeys = '0; repeat (8) tick;
    check("multi_clear", ma, 0);

    // Reset coincident with a strobe, key kept held
    inkeys = 20'h00004;
    w = 0;
    while (!sa && w < 20) begin tick; w++; end
    check("rst_strobe_seen", sa, 1);
    reset = 1'b1;
    #1;
    check("rst_immediate", {sa, ka, ha, ma, sb, kb, hb, mb}, 32'h0);
    repeat (2) tick;
    reset = 1'b0;
    c0 = cyc;
    str_a = 0;
    repeat (8) tick;
    check("rst_restrobe_count", str_a, 1);
    check("rst_restrobe_latency", last_a - c0, 5);
    check("rst_key", ka, 2);
    inkeys = '0; repeat (8) tick;

    // Randomised traffic against the model
    for (int seg = 0; seg < 300; seg++) begin
      case ($urandom_range(0, 3))
        0: rk = 20'(1) << $urandom_range(0, 19);
        1: rk = (20'(1) << $urandom_range(0, 19)) | (20'(1) << $urandom_range(0, 19));
        2: rk = '0;
        default: rk = 20'($urandom);
      endcase
      inkeys = rk;
      if ($urandom_range(0, 9) == 0) repeat (30) tick;
      else repeat ($urandom_range(1, 14)) tick;
    end
    inkeys = '0;
    repeat (10) tick;
    check("final_idle", {ha, hb}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/keypad_event.md
# keypad_event

Debounced keypad event generator for the 20-button calculator front end. Synchronises raw push-button inputs and priority-encodes them to a 5-bit key code. Emits exactly one single-cycle `strobe` per debounced press, with optional auto-repeat while the key is held. Replaces the two-flop delay strobe feeding the calculator datapath; `outkey` and `strobe` connect directly to its key inputs.

## Interface
- `DEBOUNCE`, 3: consecutive stable samples required to accept a press or a release; legal range 2..255.
- `REPEAT_DELAY`, 50: cycles from the initial strobe to the first repeat strobe; legal range 2..65535.
- `REPEAT_PERIOD`, 10: cycles between subsequent repeat strobes; legal range 2..65535.
- `REPEAT_EN`, 1: 1 enables auto-repeat, 0 disables it.

Ports:
- `clk`  in  1  system clock (100 Hz on the board).
- `reset`  in  1  asynchronous, active-high.
- `inkeys`  in  20  raw push-button levels, active-high, asynchronous to `clk`.
- `strobe`  out  1  registered, one-cycle pulse per accepted press or repeat.
- `outkey`  out  5  registered code of the accepted key, 0..19; holds its value until the next strobe.
- `held`  out  1  registered; high while an accepted key is considered held.
- `multi`  out  1  registered; high when more than one synchronised key bit is set.

## Operation
- **Reset values.** `reset` clears to 0: `strobe`, `outkey`, `held`, `multi`, both synchroniser stages, all counters. FSM goes to IDLE. Reset takes effect immediately, including mid-pulse.
- **Synchroniser.** Two-flop synchroniser on all 20 bits produces `s`.
- **Encoder.** `any = |s`. `code` is the highest asserted bit index of `s`, or 0 if none. `multi` registers "popcount(`s`) > 1" every cycle.
- **Press debounce counter.** `dcnt` is 8 bits. **Repeat counter.** `rcnt` is 16 bits. Neither counter wraps.
- **IDLE:**
  - `any` → `dcnt`=1, `cand`=`code`, go to PRESS_DB.
- **PRESS_DB:**
  - `!any` → IDLE.
  - `code`≠`cand` → `cand`=`code`, `dcnt`=1.
  - `dcnt`==`DEBOUNCE`-1 → assert `strobe`, `outkey`=`cand`, `held`=1, `rcnt`=0, go to HELD.
  - Otherwise `dcnt`++.
- **HELD:**
  - `!any` → `dcnt`=1, go to REL_DB.
  - A change in `code` while held is ignored; no event fires until a full release.
  - If `REPEAT_EN` and `rcnt`==`REPEAT_DELAY`-1 → `strobe`, `rcnt`=0, go to REPEAT.
  - Otherwise `rcnt`++ (saturating).
- **REPEAT:**
  - Same as HELD, but uses `REPEAT_PERIOD` and stays in REPEAT after each strobe.
- **REL_DB:**
  - `any` → return to HELD with `rcnt`=0 and no strobe. This rule applies even if REL_DB was entered from REPEAT.
  - `dcnt`==`DEBOUNCE`-1 → `held`=0, go to IDLE.
  - Otherwise `dcnt`++.
- **Strobe rules.**
  - `strobe` is high for exactly one cycle per event.
  - Two strobes are never adjacent, because the minimum spacing is 2.

## Timing
- Number edges from the first `clk` edge that samples the stable `inkeys` as edge 1.
- `s` is valid after edge 2.
- The FSM observes the press on edges 3 .. `DEBOUNCE`+2.
- `strobe`, `outkey`, and `held` update after edge `DEBOUNCE`+2. Press latency is `DEBOUNCE`+2 cycles.
- `strobe` deasserts after the next edge.
- Release latency: `held` falls `DEBOUNCE`+2 cycles after `inkeys` goes all-zero.
- First repeat strobe: `REPEAT_DELAY` cycles after the initial strobe. Later repeat strobes: every `REPEAT_PERIOD` cycles.
- `multi` lags `inkeys` by 3 edges.
- Any bounce shorter than `DEBOUNCE` samples restarts the relevant count. A glitch never produces a strobe.

## Test plan
1. **Clean press, no repeat.** `DEBOUNCE`=3, `REPEAT_EN`=0. Hold bit 5 for 20 cycles, then release.
   → One strobe after edge 5 with `outkey`=5. `held` rises with the strobe and falls 5 cycles after release. No other strobes.
2. **Press bounce.** Bit 7 toggles 1,0,1,0 on successive cycles, then stays at 1.
   → Exactly one strobe, 5 cycles after the stable level begins, with `outkey`=7.
3. **Key change during debounce.** Bit 3 for 2 cycles, then bit 12 only.
   → Single strobe with `outkey`=12, 5 cycles after the switch. No strobe for key 3.
4. **Auto-repeat.** `REPEAT_DELAY`=5, `REPEAT_PERIOD`=2. Hold bit 17 for 20 cycles.
   → Strobes at T, T+5, T+7, T+9, … while held (T = initial strobe). All carry `outkey`=17.
5. **Simultaneous keys.** Bits 4 and 19 asserted together.
   → `multi`=1 after 3 edges. Single strobe with `outkey`=19. Adding bit 0 while held produces no new strobe.
6. **Reset mid-operation.** Assert `reset` in HELD coincident with a strobe, with the key still held.
   → All outputs go to 0 immediately. After `reset` drops, a fresh strobe follows `DEBOUNCE`+2 cycles later.
